// File: rtl/regfile_dump_reader_pkg.sv
// Shared defaults and state encoding for the register-file dump reader.
package regfile_dump_reader_pkg;

    localparam int unsigned REGDUMP_DATA_W   = 32;
    localparam int unsigned REGDUMP_ADDR_W   = 5;
    localparam int unsigned REGDUMP_NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register-file debug read port and streams every register as a valid/ready beat.
// Optional trailing XOR checksum beat when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int unsigned DATA_W   = REGDUMP_DATA_W,
    parameter int unsigned ADDR_W   = REGDUMP_ADDR_W,
    parameter int unsigned NUM_REGS = REGDUMP_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_ptr, fetch_ptr_n;
    logic              out_valid_n, out_last_n, busy_n, done_n;
    logic [DATA_W-1:0] out_data_n;
    logic [ADDR_W-1:0] out_idx_n;
    logic              handshake;
    logic              fetch_last;
    logic [ADDR_W-1:0] ptr_inc;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum, csum_n;
`endif

    assign rf_addr   = fetch_ptr;
    assign handshake = out_valid & out_ready;
    // Saturate so the read address never runs past the last register.
    assign ptr_inc   = (fetch_ptr == LAST_IDX) ? fetch_ptr : fetch_ptr + ADDR_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
    assign fetch_last = 1'b0;
`else
    assign fetch_last = (fetch_ptr == LAST_IDX);
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        fetch_ptr_n = fetch_ptr;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_idx_n   = out_idx;
        out_last_n  = out_last;
        busy_n      = busy;
        done_n      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_n      = csum;
`endif

        unique case (state)
            ST_IDLE: begin
                fetch_ptr_n = '0;
                if (start) begin
                    out_data_n  = rf_data;
                    out_idx_n   = fetch_ptr;
                    out_last_n  = fetch_last;
                    fetch_ptr_n = ptr_inc;
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    state_n     = ST_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_n      = rf_data;
`endif
                end
            end
            ST_SEND: begin
                if (abort) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    busy_n      = 1'b0;
                    fetch_ptr_n = '0;
                    state_n     = ST_IDLE;
                end else if (handshake) begin
`ifdef REGDUMP_CHECKSUM_EN
                    if (out_idx == LAST_IDX) begin
                        out_data_n = csum;
                        out_idx_n  = '0;
                        out_last_n = 1'b1;
                        state_n    = ST_CSUM;
                    end else begin
                        out_data_n  = rf_data;
                        out_idx_n   = fetch_ptr;
                        out_last_n  = fetch_last;
                        fetch_ptr_n = ptr_inc;
                        csum_n      = csum ^ rf_data;
                    end
`else
                    if (out_last) begin
                        out_valid_n = 1'b0;
                        done_n      = 1'b1;
                        state_n     = ST_DONE;
                    end else begin
                        out_data_n  = rf_data;
                        out_idx_n   = fetch_ptr;
                        out_last_n  = fetch_last;
                        fetch_ptr_n = ptr_inc;
                    end
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (abort) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    busy_n      = 1'b0;
                    fetch_ptr_n = '0;
                    state_n     = ST_IDLE;
                end else if (handshake) begin
                    out_valid_n = 1'b0;
                    done_n      = 1'b1;
                    state_n     = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                busy_n      = 1'b0;
                fetch_ptr_n = '0;
                state_n     = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            fetch_ptr <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_n;
            fetch_ptr <= fetch_ptr_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_idx   <= out_idx_n;
            out_last  <= out_last_n;
            busy      <= busy_n;
            done      <= done_n;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: randomized register contents and sink stalls
// compared against an expected beat list built directly from the register array.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int unsigned DW = REGDUMP_DATA_W;
    localparam int unsigned AW = REGDUMP_ADDR_W;
    localparam int unsigned NR = REGDUMP_NUM_REGS;

    typedef struct {
        int unsigned    idx;
        logic [DW-1:0]  data;
        logic           last;
    } beat_t;

    logic          clk, rst, start, abort, out_ready;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid, out_last, busy, done;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;

    logic [DW-1:0] rf [NR];
    assign rf_data = rf[rf_addr];

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t got[$];
    beat_t exp_q[$];
    int    done_cnt, stall_err;
    bit    timed_out;
    logic  first_valid;

    // Expected dump: one beat per register at its current value, plus optional XOR beat.
    task automatic build_exp();
        beat_t         b;
        logic [DW-1:0] acc;
        exp_q.delete();
        acc = '0;
        for (int i = 0; i < int'(NR); i++) begin
            b.idx  = i;
            b.data = rf[i];
            acc    = acc ^ rf[i];
`ifdef REGDUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == int'(NR) - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef REGDUMP_CHECKSUM_EN
        b.idx = 0; b.data = acc; b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // Drives one dump and records accepted beats; mode 0 ready=1, 1 pattern 1001, 2 random.
    task automatic run_dump(input int mode, input bit spam, input int abort_idx, input bit abort_with_start);
        bit            stalled, fin;
        logic [DW-1:0] pd;
        logic [AW-1:0] pi;
        logic          pl;
        beat_t         b;
        int            cyc;
        got.delete();
        done_cnt = 0; stall_err = 0; timed_out = 0; stalled = 0; fin = 0; cyc = 0;
        pd = '0; pi = '0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1; abort = abort_with_start; out_ready = 1'b0;
        @(negedge clk);
        start = spam; abort = 1'b0;
        first_valid = out_valid;
        while (!fin) begin
            if (stalled && (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi || out_last !== pl))
                stall_err++;
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b1) fin = 1;
            else if (cyc >= 400) begin timed_out = 1; fin = 1; end
            else begin
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                abort = (abort_idx >= 0) && out_valid && (int'(out_idx) == abort_idx);
                if (abort) out_ready = 1'b1;
                if (out_valid && out_ready && !abort) begin
                    b.idx = out_idx; b.data = out_data; b.last = out_last;
                    got.push_back(b);
                end
                stalled = out_valid && !out_ready;
                pd = out_data; pi = out_idx; pl = out_last;
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({out_valid, out_data, out_idx, out_last, busy, done, rf_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b addr=%0d, want all zero",
                     out_valid, out_data, out_idx, out_last, busy, done, rf_addr);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < int'(NR); i++) rf[i] = DW'(32'h1000 + i);
        build_exp();
        run_dump(0, 0, -1, 0);
        n_vec++;
        if (first_valid !== 1'b1) begin
            n_err++; $display("FAIL full_latency: got valid=%b one cycle after start, want 1", first_valid);
        end
        n_vec++;
        if (got.size() != exp_q.size() || timed_out) begin
            n_err++; $display("FAIL full_count: got %0d beats (timeout=%0d), want %0d", got.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got[i].idx != exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                n_err++;
                $display("FAIL full_beat %0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                         i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
            end
        end
        n_vec++;
        if (done_cnt != 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL full_done: got done_cnt=%0d busy=%b valid=%b, want 1 0 0", done_cnt, busy, out_valid);
        end
    endtask

    task automatic test_stall_pattern();
        build_exp();
        run_dump(1, 0, -1, 0);
        n_vec++;
        if (stall_err != 0 || timed_out) begin
            n_err++; $display("FAIL stall_hold: got %0d unstable stall cycles (timeout=%0d), want 0", stall_err, timed_out);
        end
        n_vec++;
        if (got.size() != exp_q.size()) begin
            n_err++; $display("FAIL stall_count: got %0d beats, want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got[i].idx != exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                n_err++;
                $display("FAIL stall_beat %0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                         i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_start_spam();
        build_exp();
        run_dump(0, 1, -1, 0);
        n_vec++;
        if (got.size() != exp_q.size() || done_cnt != 1 || timed_out) begin
            n_err++; $display("FAIL spam_count: got %0d beats %0d done, want %0d beats 1 done", got.size(), done_cnt, exp_q.size());
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL spam_restart: got valid=%b busy=%b after dump, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_abort();
        build_exp();
        run_dump(0, 0, 10, 0);
        n_vec++;
        if (got.size() != 10 || done_cnt != 0 || timed_out) begin
            n_err++; $display("FAIL abort_count: got %0d beats %0d done, want 10 beats 0 done", got.size(), done_cnt);
        end
        n_vec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_state: got valid=%b last=%b busy=%b, want 0 0 0", out_valid, out_last, busy);
        end
        for (int c = 0; c < 3; c++) begin
            abort = 1'b1;
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_err++; $display("FAIL abort_idle: got valid=%b busy=%b done=%b, want 0 0 0", out_valid, busy, done);
            end
        end
        abort = 1'b0;
        // Replay from idx 0 with start and abort raised together.
        run_dump(0, 0, -1, 1);
        n_vec++;
        if (got.size() != exp_q.size() || done_cnt != 1) begin
            n_err++; $display("FAIL abort_replay_count: got %0d beats %0d done, want %0d 1", got.size(), done_cnt, exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got[i].idx != exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                n_err++;
                $display("FAIL replay_beat %0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                         i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        bit found;
        found = 0;
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (out_valid && out_idx == AW'(20)) found = 1;
            else @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (!found || {out_valid, out_data, out_idx, out_last, busy, done, rf_addr} !== '0) begin
            n_err++;
            $display("FAIL midrst_state: reached=%0d got valid=%b data=%h idx=%0d last=%b busy=%b done=%b addr=%0d, want all zero",
                     found, out_valid, out_data, out_idx, out_last, busy, done, rf_addr);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        build_exp();
        run_dump(0, 0, -1, 0);
        n_vec++;
        if (got.size() != exp_q.size() || done_cnt != 1 || timed_out) begin
            n_err++; $display("FAIL midrst_redump: got %0d beats %0d done, want %0d 1", got.size(), done_cnt, exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got[i].idx != exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                n_err++;
                $display("FAIL midrst_beat %0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                         i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < int'(NR); i++) rf[i] = DW'($urandom);
            build_exp();
            run_dump(2, 1'($urandom_range(0, 1)), -1, 0);
            n_vec++;
            if (got.size() != exp_q.size() || done_cnt != 1 || stall_err != 0 || timed_out) begin
                n_err++;
                $display("FAIL rand_run %0d: got %0d beats %0d done %0d unstable, want %0d 1 0",
                         r, got.size(), done_cnt, stall_err, exp_q.size());
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                n_vec++;
                if (got[i].idx != exp_q[i].idx || got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
                    n_err++;
                    $display("FAIL rand_beat %0d.%0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                             r, i, got[i].idx, got[i].data, got[i].last, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
                end
            end
        end
    endtask

`ifdef REGDUMP_CHECKSUM_EN
    task automatic test_checksum();
        logic [DW-1:0] want_csum;
        for (int i = 0; i < int'(NR); i++) rf[i] = DW'(i);
        rf[5] = DW'(32'hDEADBEEF);
        want_csum = DW'(32'hDEADBEEA);
        run_dump(0, 0, -1, 0);
        n_vec++;
        if (got.size() != int'(NR) + 1) begin
            n_err++; $display("FAIL csum_count: got %0d beats, want %0d", got.size(), NR + 1);
        end else begin
            n_vec++;
            if (got[NR].data !== want_csum || got[NR].idx != 0 || got[NR].last !== 1'b1 || got[NR-1].last !== 1'b0) begin
                n_err++;
                $display("FAIL csum_beat: got data=%h idx=%0d last=%b prev_last=%b, want %h 0 1 0",
                         got[NR].data, got[NR].idx, got[NR].last, got[NR-1].last, want_csum);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < int'(NR); i++) rf[i] = '0;
        test_reset();
        test_full_dump();
        test_stall_pattern();
        test_start_spam();
        test_abort();
        test_reset_mid_dump();
        test_random();
`ifdef REGDUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
